// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among N_REQ requesters: round-robin grant, in-order tag FIFO, products routed by tag. Optional MULT_ARB_STATS_EN adds stat_issued/stat_stall.
// Latency: request accept -> resp_tvalid = 1 + multiplier latency + 1 cycles.
// Backpressure: grants stop when the issue register is busy or MAX_INFLIGHT products are in flight; a held response deasserts mul_out_tready.
module mult_share_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ*DATA_W-1:0]   req_a_tdata,
  input  logic [N_REQ*DATA_W-1:0]   req_b_tdata,
  input  logic [N_REQ-1:0]          req_tvalid,
  output logic [N_REQ-1:0]          req_tready,
  output logic [2*DATA_W-1:0]       resp_tdata,
  output logic [N_REQ-1:0]          resp_tvalid,
  input  logic [N_REQ-1:0]          resp_tready,
  output logic [DATA_W-1:0]         mul_a_tdata,
  output logic [DATA_W-1:0]         mul_b_tdata,
  output logic                      mul_tvalid,
  input  logic                      mul_a_tready,
  input  logic                      mul_b_tready,
  input  logic [2*DATA_W-1:0]       mul_out_tdata,
  input  logic                      mul_out_tvalid,
  output logic                      mul_out_tready,
  output logic                      err_tag
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_stall
`endif
);

  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = PW + 1;

  logic [TW-1:0] rr_ptr, grant_idx, issue_tag, resp_tag;
  logic          grant_any, grant_ok, rdy_en, req_acc, issue_hs;
  logic          resp_full, resp_accept, out_hs, prod_hs, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tag_mem [MAX_INFLIGHT];

  function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return TW'(s);
  endfunction

  assign issue_hs   = mul_tvalid & mul_a_tready & mul_b_tready;
  assign fifo_empty = (fifo_count == '0);
  // rdy_en keeps req_tready low during reset and the first cycle after release
  assign grant_ok   = rdy_en && (!mul_tvalid || issue_hs) &&
                      ((int'(fifo_count) + int'(mul_tvalid)) < MAX_INFLIGHT);

  // Scan from the highest offset down so the lowest offset from rr_ptr wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_tvalid[rr_idx(rr_ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = rr_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    req_tready  = '0;
    resp_tvalid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_tready[i]  = grant_ok && grant_any && (grant_idx == TW'(i));
      resp_tvalid[i] = resp_full && (resp_tag == TW'(i));
    end
  end

  assign req_acc = |(req_tvalid & req_tready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en      <= 1'b0;
      rr_ptr      <= '0;
      mul_tvalid  <= 1'b0;
      mul_a_tdata <= '0;
      mul_b_tdata <= '0;
      issue_tag   <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (req_acc) begin
        mul_tvalid  <= 1'b1;
        mul_a_tdata <= req_a_tdata[grant_idx*DATA_W +: DATA_W];
        mul_b_tdata <= req_b_tdata[grant_idx*DATA_W +: DATA_W];
        issue_tag   <= grant_idx;
        rr_ptr      <= rr_idx(grant_idx, 1);
      end else if (issue_hs) begin
        mul_tvalid <= 1'b0;
      end
    end
  end

  // In-order tag FIFO: one entry per product inside the multiplier
  assign resp_accept    = resp_full & resp_tready[resp_tag];
  assign mul_out_tready = !resp_full | resp_accept;
  assign out_hs         = mul_out_tvalid & mul_out_tready;
  assign prod_hs        = out_hs & !fifo_empty;

  always_ff @(posedge clk) begin
    if (issue_hs) tag_mem[wr_ptr] <= issue_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (issue_hs) wr_ptr <= wr_ptr + 1'b1;
      if (prod_hs)  rd_ptr <= rd_ptr + 1'b1;
      case ({issue_hs, prod_hs})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_full  <= 1'b0;
      resp_tag   <= '0;
      resp_tdata <= '0;
      err_tag    <= 1'b0;
    end else begin
      if (resp_accept) resp_full <= 1'b0;
      if (prod_hs) begin
        resp_full  <= 1'b1;
        resp_tag   <= tag_mem[rd_ptr];
        resp_tdata <= mul_out_tdata;
      end
      // An untagged product is dropped; the flag stays set until reset
      if (out_hs && fifo_empty) err_tag <= 1'b1;
    end
  end

`ifdef MULT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue_hs) stat_issued <= stat_issued + 32'd1;
      if ((|req_tvalid) && !(|req_tready)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a queue-based multiplier stub.
module tb_mult_share_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 3;

  typedef struct packed { logic [DW-1:0] a; logic [DW-1:0] b; } op_t;
  typedef struct { int idx; logic [2*DW-1:0] prod; int acc_edge; bit lat; } sb_t;
  typedef struct { logic [2*DW-1:0] prod; int due; } mq_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*DW-1:0]   req_a_tdata = '0, req_b_tdata = '0;
  logic [N-1:0]      req_tvalid = '0, req_tready;
  logic [2*DW-1:0]   resp_tdata;
  logic [N-1:0]      resp_tvalid, resp_tready = '1;
  logic [DW-1:0]     mul_a_tdata, mul_b_tdata;
  logic              mul_tvalid, mul_a_tready = 1'b1, mul_b_tready = 1'b1;
  logic [2*DW-1:0]   mul_out_tdata = '0;
  logic              mul_out_tvalid = 1'b0, mul_out_tready, err_tag;
`ifdef MULT_ARB_STATS_EN
  logic [31:0]       stat_issued, stat_stall;
`endif

  mult_share_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_tdata(req_a_tdata), .req_b_tdata(req_b_tdata),
    .req_tvalid(req_tvalid), .req_tready(req_tready),
    .resp_tdata(resp_tdata), .resp_tvalid(resp_tvalid), .resp_tready(resp_tready),
    .mul_a_tdata(mul_a_tdata), .mul_b_tdata(mul_b_tdata), .mul_tvalid(mul_tvalid),
    .mul_a_tready(mul_a_tready), .mul_b_tready(mul_b_tready),
    .mul_out_tdata(mul_out_tdata), .mul_out_tvalid(mul_out_tvalid),
    .mul_out_tready(mul_out_tready), .err_tag(err_tag)
`ifdef MULT_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  int   cyc = 0, n_issued = 0, n_acc = 0, stall_cnt = 0, exp_rr = 0;
  bit   mul_hold = 0, inject = 0, rand_rdy = 0, lat_chk = 0;
  logic [N-1:0] rt_mask = '1;
  op_t  src_q [N][$];
  sb_t  sb [$];
  mq_t  mq [$];

  bit              prev_rhold = 0, prev_mhold = 0;
  logic [2*DW-1:0] prev_rdat;
  logic [N-1:0]    prev_rvld;
  logic [DW-1:0]   prev_ma, prev_mb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Multiplier stub: fixed latency, presents products in order, reset from ~rst_n
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mul_out_tvalid <= 1'b0;
      n_issued = 0;
    end else begin
      cyc++;
      if (mul_out_tvalid && mul_out_tready) void'(mq.pop_front());
      if (mul_tvalid && mul_a_tready && mul_b_tready) begin
        mq.push_back('{prod: {32'b0, mul_a_tdata} * {32'b0, mul_b_tdata}, due: cyc + LAT});
        n_issued++;
      end
      if (inject) mq.push_back('{prod: 64'hDEAD_BEEF_0BAD_F00D, due: cyc});
      if (!mul_hold && mq.size() > 0 && mq[0].due <= cyc) begin
        mul_out_tvalid <= 1'b1;
        mul_out_tdata  <= mq[0].prod;
      end else begin
        mul_out_tvalid <= 1'b0;
      end
    end
  end

  // Requester drivers, response sink, grant model and scoreboard checks
  always @(negedge clk) begin
    int g, ga;
    bit acc;
    sb_t e;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_tvalid[i] = 1'b1;
        req_a_tdata[i*DW +: DW] = src_q[i][0].a;
        req_b_tdata[i*DW +: DW] = src_q[i][0].b;
      end else begin
        req_tvalid[i] = 1'b0;
      end
    end
    resp_tready  = rt_mask;
    mul_b_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (!rst_n) begin
      exp_rr = 0; prev_rhold = 0; prev_mhold = 0;
    end else begin
      if ((|req_tvalid) && req_tready == '0) stall_cnt++;
      if (req_tready != '0) begin
        g = -1; ga = 0;
        for (int k = N - 1; k >= 0; k--) if (req_tvalid[(exp_rr + k) % N]) g = (exp_rr + k) % N;
        chk("grant", 64'(req_tready), (g < 0) ? 64'd0 : (64'd1 << g));
        for (int j = N - 1; j >= 0; j--) if (req_tready[j]) ga = j;
        if (src_q[ga].size() > 0) begin
          sb.push_back('{idx: ga, prod: {32'b0, src_q[ga][0].a} * {32'b0, src_q[ga][0].b},
                         acc_edge: cyc + 1, lat: lat_chk});
          void'(src_q[ga].pop_front());
          n_acc++;
        end
        exp_rr = (ga + 1) % N;
      end
      if (prev_mhold) begin
        chk("mul_vld_hold", 64'(mul_tvalid), 64'd1);
        chk("mul_a_hold", 64'(mul_a_tdata), 64'(prev_ma));
        chk("mul_b_hold", 64'(mul_b_tdata), 64'(prev_mb));
      end
      prev_mhold = mul_tvalid && !(mul_a_tready && mul_b_tready);
      prev_ma = mul_a_tdata; prev_mb = mul_b_tdata;

      if (prev_rhold) begin
        chk("resp_dat_hold", resp_tdata, prev_rdat);
        chk("resp_vld_hold", 64'(resp_tvalid), 64'(prev_rvld));
      end
      acc = |(resp_tvalid & resp_tready);
      if (resp_tvalid != '0) begin
        chk("resp_onehot", 64'($onehot(resp_tvalid)), 64'd1);
        chk("resp_owner_pending", 64'(sb.size() != 0), 64'd1);
        chk("out_tready", 64'(mul_out_tready), 64'(acc));
      end
      if (acc && sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_idx", 64'(resp_tvalid), 64'd1 << e.idx);
        chk("resp_dat", resp_tdata, e.prod);
        if (e.lat) chk("latency", 64'(cyc - e.acc_edge), 64'(2 + LAT));
      end
      prev_rhold = (resp_tvalid != '0) && !acc;
      prev_rdat = resp_tdata; prev_rvld = resp_tvalid;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    src_q[i].push_back('{a: a, b: b});
  endtask

  task automatic wait_drain(input int max_cyc);
    int busy;
    for (int c = 0; c < max_cyc; c++) begin
      busy = sb.size();
      for (int i = 0; i < N; i++) busy += src_q[i].size();
      if (busy == 0) break;
      cycles(1);
    end
    busy = sb.size();
    for (int i = 0; i < N; i++) busy += src_q[i].size();
    chk("drain", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    cycles(3);
    chk("rst_req_tready", 64'(req_tready), 64'd0);
    chk("rst_resp_tvalid", 64'(resp_tvalid), 64'd0);
    chk("rst_mul_tvalid", 64'(mul_tvalid), 64'd0);
    chk("rst_err_tag", 64'(err_tag), 64'd0);
    chk("rst_out_tready", 64'(mul_out_tready), 64'd1);
    rst_n = 1'b1;
    cycles(2);

    // T1: single request, known product and latency
    lat_chk = 1;
    push_req(0, 32'h0001_0002, 32'h0003_0004);
    for (int c = 0; c < 30 && resp_tvalid == '0; c++) cycles(1);
    chk("t1_vld", 64'(resp_tvalid), 64'h1);
    chk("t1_dat", resp_tdata, 64'h0000_0003_000A_0008);
    wait_drain(50);
    lat_chk = 0;

    // T2: all requesters busy, multiplier input stalls randomly
    rand_rdy = 1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_req(i, $urandom, $urandom);
    wait_drain(300);
    rand_rdy = 0;

    // T3: multiplier output withheld -> FIFO fills at 4, 5th waits
    mul_hold = 1;
    base = n_acc;
    for (int r = 0; r < 5; r++) push_req(1, $urandom, $urandom);
    cycles(15);
    chk("t3_acc4", 64'(n_acc - base), 64'd4);
    chk("t3_rdy0", 64'(req_tready), 64'd0);
    chk("t3_issued", 64'(n_issued), 64'(13 + 4));
    mul_hold = 0;
    for (int c = 0; c < 20 && (n_acc - base) < 5; c++) cycles(1);
    chk("t3_acc5", 64'(n_acc - base), 64'd5);
    wait_drain(100);

    // T4: requester 2 refuses its response for 10 cycles
    rt_mask = 4'b1011;
    for (int r = 0; r < 2; r++) begin
      push_req(2, $urandom, $urandom);
      push_req(0, $urandom, $urandom);
    end
    cycles(10);
    chk("t4_vld", 64'(resp_tvalid), 64'h4);
    chk("t4_out_tready", 64'(mul_out_tready), 64'd0);
    rt_mask = '1;
    wait_drain(100);

    // T5: reset with products in flight
    push_req(0, $urandom, $urandom);
    push_req(1, $urandom, $urandom);
    push_req(3, $urandom, $urandom);
    cycles(3);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    stall_cnt = 0;
    #1;
    chk("t5_req_tready", 64'(req_tready), 64'd0);
    chk("t5_resp_tvalid", 64'(resp_tvalid), 64'd0);
    chk("t5_mul_tvalid", 64'(mul_tvalid), 64'd0);
    chk("t5_out_tready", 64'(mul_out_tready), 64'd1);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    push_req(3, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_drain(50);
    chk("t5_err_tag", 64'(err_tag), 64'd0);

    // T6: product with no tag outstanding
    cycles(3);
    inject = 1;
    cycles(1);
    inject = 0;
    cycles(6);
    chk("t6_err_tag", 64'(err_tag), 64'd1);
    cycles(5);
    chk("t6_err_sticky", 64'(err_tag), 64'd1);
    chk("t6_no_resp", 64'(resp_tvalid), 64'd0);
`ifdef MULT_ARB_STATS_EN
    chk("stat_issued", 64'(stat_issued), 64'(n_issued));
    chk("stat_stall", 64'(stat_stall), 64'(stall_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
